// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: line-aligns, de-duplicates and credit-throttles prefetches toward the lower cache.
// Optional saturating statistics outputs are enabled by defining PREFETCH_ISSUE_QUEUE_STATS_EN.
module prefetch_issue_queue #(
    parameter int WIDTH           = 64,
    parameter int LOGLINE         = 6,
    parameter int QDEPTH          = 8,
    parameter int RECENT          = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WIDTH-1:0]                     pf_addr_i,
    input  logic                                 pf_valid_i,
    input  logic [WIDTH-1:0]                     demand_addr_i,
    input  logic                                 demand_valid_i,
    output logic [WIDTH-1:0]                     lo_req_addr_o,
    output logic                                 lo_req_valid_o,
    input  logic                                 lo_req_ready_i,
    input  logic                                 lo_fill_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
`ifdef PREFETCH_ISSUE_QUEUE_STATS_EN
    ,
    output logic [31:0]                          stat_issued_o,
    output logic [31:0]                          stat_dropped_o,
    output logic [31:0]                          stat_filtered_o
`endif
);
    localparam int LW = WIDTH - LOGLINE;
    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;
    localparam int RW = (RECENT > 1) ? $clog2(RECENT) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [QDEPTH-1:0][LW-1:0] r_line;
    logic [QDEPTH-1:0]         r_live;
    logic [QW-1:0]             r_head, r_tail;
    logic [CW-1:0]             r_count;
    logic [RECENT-1:0][LW-1:0] r_rline;
    logic [RECENT-1:0]         r_rvld;
    logic [RW-1:0]             r_rptr;
    logic [OW-1:0]             r_out;

    logic [LW-1:0]     w_pf_line, w_dm_line;
    logic              w_dup, w_rhit, w_dhit, w_full, w_enq;
    logic              w_valid, w_fire, w_pop, w_dec;
    logic [QDEPTH-1:0] w_squash, w_live_nxt;
    logic              w_unused;

    assign w_pf_line = pf_addr_i[WIDTH-1:LOGLINE];
    assign w_dm_line = demand_addr_i[WIDTH-1:LOGLINE];
    assign w_unused  = ^{pf_addr_i[LOGLINE-1:0], demand_addr_i[LOGLINE-1:0]};

    assign w_valid = (r_count != '0) && r_live[r_head] && (r_out < OW'(MAX_OUTSTANDING));
    assign w_fire  = w_valid && lo_req_ready_i;
    // A dead head drains for free; a live head leaves only by firing.
    assign w_pop   = (r_count != '0) && (!r_live[r_head] || w_fire);
    assign w_dec   = lo_fill_i && (r_out != '0);
    assign w_full  = (r_count == CW'(QDEPTH));
    assign w_dhit  = demand_valid_i && (w_dm_line == w_pf_line);
    assign w_enq   = pf_valid_i && !w_dup && !w_rhit && !w_dhit && !w_full;

    assign lo_req_valid_o = w_valid;
    assign lo_req_addr_o  = w_valid ? {r_line[r_head], {LOGLINE{1'b0}}} : '0;
    assign outstanding_o  = r_out;

    always_comb begin
        w_dup    = 1'b0;
        w_squash = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (r_live[i] && r_line[i] == w_pf_line) w_dup = 1'b1;
            // The presented head must stay stable until accepted.
            if (demand_valid_i && r_live[i] && r_line[i] == w_dm_line &&
                !(QW'(i) == r_head && w_valid))
                w_squash[i] = 1'b1;
        end
    end

    always_comb begin
        w_rhit = 1'b0;
        for (int j = 0; j < RECENT; j++)
            if (r_rvld[j] && r_rline[j] == w_pf_line) w_rhit = 1'b1;
    end

    always_comb begin
        w_live_nxt = r_live & ~w_squash;
        if (w_pop) w_live_nxt[r_head] = 1'b0;
        if (w_enq) w_live_nxt[r_tail] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_enq)  r_line[r_tail]  <= w_pf_line;
        if (w_fire) r_rline[r_rptr] <= r_line[r_head];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_live  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rvld  <= '0;
            r_rptr  <= '0;
            r_out   <= '0;
        end else begin
            r_live <= w_live_nxt;
            if (w_pop) r_head <= r_head + 1'b1;
            if (w_enq) r_tail <= r_tail + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_fire) begin
                r_rvld[r_rptr] <= 1'b1;
                r_rptr <= (r_rptr == RW'(RECENT-1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_fire, w_dec})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
        end
    end

`ifdef PREFETCH_ISSUE_QUEUE_STATS_EN
    logic [31:0] r_stat_iss, r_stat_drop, r_stat_filt;
    logic [CW-1:0] w_nsq;
    logic        w_filt_drop, w_full_drop;
    logic [32:0] w_fsum;

    always_comb begin
        w_nsq = '0;
        for (int k = 0; k < QDEPTH; k++) w_nsq = w_nsq + CW'(w_squash[k]);
    end

    assign w_filt_drop = pf_valid_i && (w_dup || w_rhit || w_dhit);
    assign w_full_drop = pf_valid_i && !(w_dup || w_rhit || w_dhit) && w_full;
    assign w_fsum      = {1'b0, r_stat_filt} + 33'(w_nsq) + 33'(w_filt_drop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_iss  <= '0;
            r_stat_drop <= '0;
            r_stat_filt <= '0;
        end else begin
            if (w_fire && r_stat_iss != '1)       r_stat_iss  <= r_stat_iss + 1'b1;
            if (w_full_drop && r_stat_drop != '1) r_stat_drop <= r_stat_drop + 1'b1;
            r_stat_filt <= w_fsum[32] ? '1 : w_fsum[31:0];
        end
    end

    assign stat_issued_o   = r_stat_iss;
    assign stat_dropped_o  = r_stat_drop;
    assign stat_filtered_o = r_stat_filt;
`endif
endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed bench for prefetch_issue_queue: queueing, filtering, squash, credits and reset.
module tb_prefetch_issue_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pf_addr_i, demand_addr_i, lo_req_addr_o;
    logic        pf_valid_i, demand_valid_i, lo_req_valid_o, lo_req_ready_i, lo_fill_i;
    logic [3:0]  outstanding_o;
`ifdef PREFETCH_ISSUE_QUEUE_STATS_EN
    logic [31:0] stat_issued_o, stat_dropped_o, stat_filtered_o;
`endif

    int          n_vec = 0, n_err = 0, nfire = 0;
    logic [63:0] fires[$];

    prefetch_issue_queue dut (
        .clk(clk), .rst(rst),
        .pf_addr_i(pf_addr_i), .pf_valid_i(pf_valid_i),
        .demand_addr_i(demand_addr_i), .demand_valid_i(demand_valid_i),
        .lo_req_addr_o(lo_req_addr_o), .lo_req_valid_o(lo_req_valid_o),
        .lo_req_ready_i(lo_req_ready_i), .lo_fill_i(lo_fill_i),
        .outstanding_o(outstanding_o)
`ifdef PREFETCH_ISSUE_QUEUE_STATS_EN
        , .stat_issued_o(stat_issued_o), .stat_dropped_o(stat_dropped_o),
        .stat_filtered_o(stat_filtered_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Log a fire before the edge that takes it, then settle past the edge.
    task automatic tick();
        #1;
        if (lo_req_valid_o && lo_req_ready_i) begin
            nfire++;
            fires.push_back(lo_req_addr_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] a);
        pf_addr_i  = a;
        pf_valid_i = 1'b1;
        tick();
        pf_valid_i = 1'b0;
    endtask

    task automatic fill();
        lo_fill_i = 1'b1;
        tick();
        lo_fill_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        nfire = 0;
        fires.delete();
    endtask

    initial begin
        pf_addr_i = '0; pf_valid_i = 0; demand_addr_i = '0; demand_valid_i = 0;
        lo_req_ready_i = 0; lo_fill_i = 0; rst = 1'b0;
        do_reset();
        chk("rst_valid", 64'(lo_req_valid_o), 64'd0);
        chk("rst_addr", lo_req_addr_o, 64'd0);
        chk("rst_out", 64'(outstanding_o), 64'd0);

        // single request, then recent-filter drop
        lo_req_ready_i = 1;
        push(64'h1234);
        chk("lat_valid", 64'(lo_req_valid_o), 64'd1);
        chk("lat_addr", lo_req_addr_o, 64'h1200);
        tick();
        chk("fire_out", 64'(outstanding_o), 64'd1);
        chk("fire_idle", 64'(lo_req_valid_o), 64'd0);
        push(64'h1238);
        chk("recent_drop", 64'(lo_req_valid_o), 64'd0);
        tick();
        chk("recent_nfire", 64'(nfire), 64'd1);
        fill();
        chk("fill_out", 64'(outstanding_o), 64'd0);

        // fill the queue with ready low; ninth line dropped
        do_reset();
        lo_req_ready_i = 0;
        for (int k = 0; k < 9; k++) push(64'(k * 64));
        chk("full_hold_v", 64'(lo_req_valid_o), 64'd1);
        chk("full_hold_a", lo_req_addr_o, 64'h0);
        lo_req_ready_i = 1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("order%0d", k), lo_req_addr_o, 64'(k * 64));
            tick();
        end
        chk("full_out8", 64'(outstanding_o), 64'd8);
        fill();
        chk("full_9th_gone", 64'(lo_req_valid_o), 64'd0);
        chk("full_out7", 64'(outstanding_o), 64'd7);
        chk("full_nfire", 64'(nfire), 64'd8);

        // credit limit
        do_reset();
        lo_req_ready_i = 1;
        for (int k = 0; k < 10; k++) push(64'h1000 + 64'(k * 64));
        repeat (4) tick();
        chk("cred_nfire", 64'(nfire), 64'd8);
        chk("cred_blocked", 64'(lo_req_valid_o), 64'd0);
        chk("cred_out", 64'(outstanding_o), 64'd8);
        fill();
        chk("cred_rel_v", 64'(lo_req_valid_o), 64'd1);
        chk("cred_rel_a", lo_req_addr_o, 64'h1200);
        chk("cred_rel_out", 64'(outstanding_o), 64'd7);
        tick();
        chk("cred_one_more", 64'(nfire), 64'd9);
        chk("cred_out8b", 64'(outstanding_o), 64'd8);
        chk("cred_block2", 64'(lo_req_valid_o), 64'd0);

        // demand squash of a non-head entry
        do_reset();
        lo_req_ready_i = 0;
        push(64'h40); push(64'h80); push(64'hC0);
        demand_addr_i = 64'h80; demand_valid_i = 1;
        tick();
        demand_valid_i = 0;
        chk("sq_head_kept", lo_req_addr_o, 64'h40);
        lo_req_ready_i = 1;
        repeat (6) tick();
        chk("sq_count", 64'(fires.size()), 64'd2);
        chk("sq_first", (fires.size() > 0) ? fires[0] : 64'hDEAD, 64'h40);
        chk("sq_second", (fires.size() > 1) ? fires[1] : 64'hDEAD, 64'hC0);

        // demand match drops a new prefetch
        do_reset();
        lo_req_ready_i = 0;
        demand_addr_i = 64'h5010; demand_valid_i = 1;
        push(64'h5000);
        demand_valid_i = 0;
        chk("dm_drop", 64'(lo_req_valid_o), 64'd0);

        // fire + fill together, fill at zero
        do_reset();
        lo_req_ready_i = 1;
        push(64'h2000); push(64'h2040); push(64'h2080);
        repeat (2) tick();
        chk("ff_out3", 64'(outstanding_o), 64'd3);
        push(64'h20C0);
        chk("ff_ready", 64'(lo_req_valid_o), 64'd1);
        fill();
        chk("ff_same", 64'(outstanding_o), 64'd3);
        fill(); fill(); fill();
        chk("ff_zero", 64'(outstanding_o), 64'd0);
        fill();
        chk("ff_nounder", 64'(outstanding_o), 64'd0);

        // reset during a held request
        do_reset();
        lo_req_ready_i = 0;
        push(64'h3000); push(64'h3040);
        chk("mid_v", 64'(lo_req_valid_o), 64'd1);
        chk("mid_a", lo_req_addr_o, 64'h3000);
        rst = 1'b0;
        tick();
        chk("mid_rst_v", 64'(lo_req_valid_o), 64'd0);
        chk("mid_rst_a", lo_req_addr_o, 64'd0);
        rst = 1'b1;
        tick();
        chk("mid_empty", 64'(lo_req_valid_o), 64'd0);
        chk("mid_out", 64'(outstanding_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/prefetch_issue_queue.md
Name: prefetch_issue_queue

Overview:
- Sits directly downstream of best_offset_prefetcher.
- Buffers the prefetch addresses it produces, line-aligns them and filters duplicates.
- Drops prefetches superseded by demand misses.
- Issues the survivors to the lower-level cache over a valid/ready handshake, throttled by an outstanding-request credit counter.

Parameters:
- WIDTH, 64, address width in bits.
- LOGLINE, 6, log2 of cache line size in bytes.
- QDEPTH, 8, queue entries; power of two, at least 2.
- RECENT, 4, entries in the recently-issued filter.
- MAX_OUTSTANDING, 8, maximum issued but unfilled prefetches.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low (0 = reset).
- pf_addr_i  input  WIDTH  prefetch byte address from the prefetcher.
- pf_valid_i  input  1  prefetch request valid; no backpressure, the request is accepted or dropped in the same cycle.
- demand_addr_i  input  WIDTH  upper-level demand miss address.
- demand_valid_i  input  1  demand miss valid.
- lo_req_addr_o  output  WIDTH  line-aligned prefetch address to the lower-level cache.
- lo_req_valid_o  output  1  prefetch request valid.
- lo_req_ready_i  input  1  lower-level cache accepts the request.
- lo_fill_i  input  1  one outstanding prefetch has completed (fill returned).
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current outstanding count.

Behaviour:
- Line address = addr >> LOGLINE; this is what is stored and compared. lo_req_addr_o = head line << LOGLINE, so the low LOGLINE bits are always 0.
- Queue: circular FIFO with head and tail pointers and a count. Each entry holds a line address and a live bit.
- Enqueue when pf_valid_i, unless any of the following holds, in which case the request is silently dropped:
  - the line matches a live queue entry;
  - the line matches a valid recent-filter entry;
  - the line matches demand_addr_i while demand_valid_i is high;
  - the queue is full.
- Full is judged on the count at the start of the cycle. A same-cycle dequeue does not make room.
- Squash: when demand_valid_i is high, every live entry with a matching line, excluding the head entry, has its live bit cleared the same cycle.
- The head is protected from squash only while lo_req_valid_o is high, so the address stays stable until accepted.
- Head processing:
  - A non-live head is popped without issue, one per cycle.
  - lo_req_valid_o = (count != 0) and head live and (outstanding < MAX_OUTSTANDING). It is combinational from registered state.
- Fire = lo_req_valid_o and lo_req_ready_i. On fire:
  - pop the head;
  - write the line into the recent filter at its round-robin pointer, mark it valid and advance the pointer (wraps at RECENT);
  - increment the outstanding count.
- Once lo_req_valid_o is high, it stays high with the same lo_req_addr_o until fire. Exception: reset.
- Outstanding counter:
  - increments on fire and decrements on lo_fill_i;
  - unchanged when both occur in the same cycle;
  - lo_fill_i at 0 is ignored (no underflow);
  - never exceeds MAX_OUTSTANDING, because the issue gate prevents it.
- Simultaneous enqueue and dequeue: both take effect, count is unchanged. This is legal at full (a dequeue at full with a new request drops the new request) and at empty (no dequeue is possible at empty).
- Pointer wrap: head and tail wrap modulo QDEPTH.
- Latency: an accepted request into an empty queue with credit available drives lo_req_valid_o the cycle after pf_valid_i.
- Reset (rst = 0 at a clock edge), including mid-handshake:
  - count, pointers and outstanding clear to 0;
  - all live and recent-valid bits clear;
  - lo_req_valid_o = 0 and lo_req_addr_o = 0 the next cycle;
  - in-flight fills are forgotten.

Optional Feature:
- Macro: PREFETCH_ISSUE_QUEUE_STATS_EN.
- When defined, three 32-bit saturating counter outputs are added:
  - stat_issued_o: counts fires.
  - stat_dropped_o: counts full-queue drops.
  - stat_filtered_o: counts duplicate, recent-filter and demand-match drops, plus squashed entries.
  - All three clear on reset.
- When undefined, none of these ports or registers exist and behaviour is otherwise identical.

Test Plan:
- Reset then idle: lo_req_valid_o=0, lo_req_addr_o=0, outstanding_o=0.
- pf_addr_i=0x1234 valid for one cycle, lo_req_ready_i=1: next cycle lo_req_addr_o=0x1200 with valid high, fire, and outstanding_o becomes 1. A second 0x1238 while 0x1200 is still in the recent filter is dropped.
- lo_req_ready_i=0, push 9 distinct lines 0x000..0x200 (stride 0x40): the first 8 are queued and the 9th is dropped. Raise ready: lines issue in order 0x000..0x1C0 (8 fires), each holding stable while ready was low.
- MAX_OUTSTANDING=8, ready=1, no fills, 10 distinct lines pushed: exactly 8 fire, then valid drops low. One lo_fill_i pulse releases exactly one more issue.
- Queue holds 0x40,0x80,0xC0 with ready=0, then demand_valid_i with demand_addr_i=0x80: 0x80 is squashed. After ready=1, the issued sequence is 0x40,0xC0.
- Fire and lo_fill_i in the same cycle at outstanding_o=3: stays 3. lo_fill_i at 0: stays 0. rst=0 asserted during a held request: valid falls the next cycle and the queue is empty.
